// File: rtl/control_smoother_pkg.sv
// Shared widths, channel indices, FSM states and output rounding for the control smoother.
package control_smoother_pkg;
  localparam int NUM_CH = 5;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 4;
  localparam int SHIFT  = 3;
  localparam int ACC_W  = DATA_W + FRAC_W;
  localparam int STEP_W = ACC_W + 2;
  localparam int CH_W   = 3;
  localparam logic [NUM_CH-1:0] BYPASS_MASK = 5'b10000;

  localparam int CH_FREQ   = 0;
  localparam int CH_HSCALE = 1;
  localparam int CH_INIT   = 2;
  localparam int CH_FOFFS  = 3;
  localparam int CH_COMB   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Round-half-up from the fixed-point accumulator, clamped to the word range.
  function automatic logic [DATA_W-1:0] acc_to_ctrl(input logic [ACC_W-1:0] acc);
    logic [ACC_W:0] r;
    r = {1'b0, acc} + (ACC_W+1)'(1 << (FRAC_W-1));
    if (r[ACC_W]) return '1;
    return r[ACC_W-1:FRAC_W];
  endfunction
endpackage

// File: rtl/control_smoother_step.sv
// One glide update: next accumulator from target, current accumulator and bypass flag.
// Purely combinational; shared across channels by the top-level sequencer.
module control_smoother_step
  import control_smoother_pkg::*;
(
  input  logic [DATA_W-1:0] target,
  input  logic [ACC_W-1:0]  acc,
  input  logic              bypass,
  output logic [ACC_W-1:0]  acc_next
);
  logic [ACC_W-1:0]         tgt_fix;
  logic signed [STEP_W-1:0] diff;
  logic signed [STEP_W-1:0] step;

  assign tgt_fix = {target, {FRAC_W{1'b0}}};
  assign diff    = $signed({2'b00, tgt_fix}) - $signed({2'b00, acc});
  assign step    = diff >>> SHIFT;

  // A zero step means the remaining error is below one LSB of the shifted diff; snap to land exactly.
  always_comb begin
    acc_next = acc + step[ACC_W-1:0];
    if (bypass || (step == '0)) acc_next = tgt_fix;
  end
endmodule

// File: rtl/control_smoother.sv
// Captures control words per ADC frame, glides each channel with a one-pole IIR, commits on sample tick.
// Latency i_Update -> o_Valid is NUM_CH+1 edges; ticks arriving mid-pass are dropped.
module control_smoother
  import control_smoother_pkg::*;
(
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic [DATA_W-1:0] i_Data0,
  input  logic [DATA_W-1:0] i_Data1,
  input  logic [DATA_W-1:0] i_Data2,
  input  logic [DATA_W-1:0] i_Data3,
  input  logic [DATA_W-1:0] i_Data4,
  input  logic              i_Data_Received,
  input  logic              i_Update,
  output logic [DATA_W-1:0] o_Ctrl0,
  output logic [DATA_W-1:0] o_Ctrl1,
  output logic [DATA_W-1:0] o_Ctrl2,
  output logic [DATA_W-1:0] o_Ctrl3,
  output logic [DATA_W-1:0] o_Ctrl4,
  output logic              o_Valid,
  output logic              o_Busy
);
  logic [DATA_W-1:0] data_in [NUM_CH];
  logic [DATA_W-1:0] target  [NUM_CH];
  logic [ACC_W-1:0]  acc     [NUM_CH];
  logic [DATA_W-1:0] ctrl    [NUM_CH];

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ch;
  logic              rcv_q;
  logic              first_frame;
  logic              frame_edge;
  logic              start;
  logic              calc_en;
  logic              commit_en;
  logic [ACC_W-1:0]  acc_next;

  assign data_in[CH_FREQ]   = i_Data0;
  assign data_in[CH_HSCALE] = i_Data1;
  assign data_in[CH_INIT]   = i_Data2;
  assign data_in[CH_FOFFS]  = i_Data3;
  assign data_in[CH_COMB]   = i_Data4;

  assign o_Ctrl0 = ctrl[CH_FREQ];
  assign o_Ctrl1 = ctrl[CH_HSCALE];
  assign o_Ctrl2 = ctrl[CH_INIT];
  assign o_Ctrl3 = ctrl[CH_FOFFS];
  assign o_Ctrl4 = ctrl[CH_COMB];

  assign frame_edge = i_Data_Received & ~rcv_q;

  control_smoother_step u_step (
    .target   (target[ch]),
    .acc      (acc[ch]),
    .bypass   (BYPASS_MASK[ch]),
    .acc_next (acc_next)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    calc_en   = 1'b0;
    commit_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_Update) begin
          start     = 1'b1;
          state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        calc_en = 1'b1;
        if (ch == CH_W'(NUM_CH-1)) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit_en = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      rcv_q       <= 1'b0;
      first_frame <= 1'b1;
      ch          <= '0;
      o_Busy      <= 1'b0;
      o_Valid     <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        target[n] <= '0;
        acc[n]    <= '0;
        ctrl[n]   <= '0;
      end
    end else begin
      rcv_q   <= i_Data_Received;
      o_Valid <= commit_en;

      if (start) begin
        ch     <= '0;
        o_Busy <= 1'b1;
      end else if (calc_en) begin
        ch <= ch + 1'b1;
      end
      if (commit_en) o_Busy <= 1'b0;

      if (calc_en) acc[ch] <= acc_next;

      // The first frame preloads the accumulators so startup does not glide up from zero.
      if (frame_edge) begin
        for (int n = 0; n < NUM_CH; n++) begin
          target[n] <= data_in[n];
          if (first_frame) acc[n] <= {data_in[n], {FRAC_W{1'b0}}};
        end
        first_frame <= 1'b0;
      end

      if (commit_en) begin
        for (int n = 0; n < NUM_CH; n++) ctrl[n] <= acc_to_ctrl(acc[n]);
      end
    end
  end
endmodule

// File: tb/tb_control_smoother.sv
// Randomized and directed stimulus against a per-channel glide model using integer arithmetic.
module tb_control_smoother;
  logic        clk;
  logic        rst_n;
  logic [15:0] d0, d1, d2, d3, d4;
  logic        data_rcv;
  logic        upd;
  logic [15:0] ctrl0, ctrl1, ctrl2, ctrl3, ctrl4;
  logic        valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Reference state: targets, fixed-point accumulators (x16), committed outputs.
  longint m_tgt [5];
  longint m_acc [5];
  longint m_out [5];
  bit     m_first;
  bit     m_byp [5] = '{0, 0, 0, 0, 1};

  control_smoother dut (
    .i_Clock         (clk),
    .i_Reset_n       (rst_n),
    .i_Data0         (d0),
    .i_Data1         (d1),
    .i_Data2         (d2),
    .i_Data3         (d3),
    .i_Data4         (d4),
    .i_Data_Received (data_rcv),
    .i_Update        (upd),
    .o_Ctrl0         (ctrl0),
    .o_Ctrl1         (ctrl1),
    .o_Ctrl2         (ctrl2),
    .o_Ctrl3         (ctrl3),
    .o_Ctrl4         (ctrl4),
    .o_Valid         (valid),
    .o_Busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, act, exp);
    end
  endtask

  function automatic longint dut_ctrl(input int n);
    case (n)
      0: return longint'(ctrl0);
      1: return longint'(ctrl1);
      2: return longint'(ctrl2);
      3: return longint'(ctrl3);
      default: return longint'(ctrl4);
    endcase
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 5; n++) begin
      m_tgt[n] = 0; m_acc[n] = 0; m_out[n] = 0;
    end
    m_first = 1'b1;
  endtask

  // Each update moves 1/8 of the remaining error (rounded toward -inf), snapping once that is zero.
  task automatic model_pass();
    for (int n = 0; n < 5; n++) begin
      longint t, e, s, o;
      t = m_tgt[n] * 16;
      e = t - m_acc[n];
      s = (e >= 0) ? e / 8 : -((-e + 7) / 8);
      if (s == 0 || m_byp[n]) m_acc[n] = t;
      else                    m_acc[n] = m_acc[n] + s;
      o = (m_acc[n] + 8) / 16;
      m_out[n] = (o > 65535) ? 65535 : o;
    end
  endtask

  task automatic do_frame(input int v0, input int v1, input int v2, input int v3, input int v4);
    int v [5];
    v = '{v0, v1, v2, v3, v4};
    @(posedge clk); #1;
    d0 = 16'(v0); d1 = 16'(v1); d2 = 16'(v2); d3 = 16'(v3); d4 = 16'(v4);
    data_rcv = 1'b1;
    @(posedge clk); #1;
    data_rcv = 1'b0;
    for (int n = 0; n < 5; n++) begin
      m_tgt[n] = v[n];
      if (m_first) m_acc[n] = longint'(v[n]) * 16;
    end
    m_first = 1'b0;
  endtask

  // One sample tick; optionally re-pulses i_Update at E3 to confirm it is dropped.
  task automatic do_pass(input string tag, input bit extra);
    int last_k;
    last_k = extra ? 12 : 7;
    @(posedge clk); #1;
    upd = 1'b1;
    @(posedge clk); #1;
    upd = 1'b0;
    model_pass();
    for (int k = 1; k <= last_k; k++) begin
      if (extra && k == 3) upd = 1'b1;
      if (extra && k == 4) upd = 1'b0;
      @(posedge clk); #1;
      if (k <= 5) begin
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_novalid"}, valid, 0);
      end else if (k == 6) begin
        chk({tag, "_valid"}, valid, 1);
        chk({tag, "_idle"}, busy, 0);
        for (int n = 0; n < 5; n++) chk($sformatf("%s_ctrl%0d", tag, n), dut_ctrl(n), m_out[n]);
      end else begin
        chk({tag, "_valid_once"}, valid, 0);
        chk({tag, "_busy_off"}, busy, 0);
      end
    end
  endtask

  initial begin
    longint prev;
    int     npass;
    rst_n = 1'b0; data_rcv = 1'b0; upd = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0; d4 = '0;
    model_reset();
    #12;
    chk("rst_ctrl0", ctrl0, 0);
    chk("rst_ctrl4", ctrl4, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // First frame loads directly: no glide from zero.
    do_frame(1000, 0, 0, 0, 0);
    do_pass("t1", 1'b0);
    chk("t1_exact", ctrl0, 1000);

    // Glide up towards 2000.
    do_frame(2000, 0, 0, 0, 0);
    prev  = 1000;
    npass = 0;
    while (m_out[0] != 2000 && npass < 150) begin
      do_pass("t2", 1'b0);
      if (npass == 0) chk("t2_step1", ctrl0, 1125);
      if (npass == 1) chk("t2_step2", ctrl0, 1234);
      chk("t2_monotonic", (longint'(ctrl0) >= prev && ctrl0 <= 16'd2000), 1);
      prev = longint'(ctrl0);
      npass++;
    end
    chk("t2_settled", ctrl0, 2000);

    // Bypass channel jumps straight to its target.
    do_frame(2000, 0, 0, 0, 37);
    do_pass("t3", 1'b0);
    chk("t3_bypass", ctrl4, 37);

    // Full-scale swing on ch1 up, then back down.
    do_frame(2000, 65535, 0, 0, 37);
    prev  = 0;
    npass = 0;
    while (m_out[1] != 65535 && npass < 150) begin
      do_pass("t5up", 1'b0);
      chk("t5_up_monotonic", longint'(ctrl1) >= prev, 1);
      prev = longint'(ctrl1);
      npass++;
    end
    chk("t5_top", ctrl1, 65535);
    do_frame(2000, 0, 0, 0, 37);
    npass = 0;
    while (m_out[1] != 0 && npass < 150) begin
      do_pass("t5dn", 1'b0);
      chk("t5_dn_monotonic", longint'(ctrl1) <= prev, 1);
      prev = longint'(ctrl1);
      npass++;
    end
    chk("t5_bottom", ctrl1, 0);

    // Second tick mid-pass is dropped.
    do_frame(3000, 500, 7, 9, 1);
    do_pass("t4", 1'b1);

    // Reset asserted mid-pass clears everything without waiting for an edge.
    @(posedge clk); #1 upd = 1'b1;
    @(posedge clk); #1 upd = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("t6_ctrl0", ctrl0, 0);
    chk("t6_ctrl1", ctrl1, 0);
    chk("t6_busy", busy, 0);
    chk("t6_valid", valid, 0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    do_pass("t6_noframe", 1'b0);
    do_frame(4321, 12345, 65535, 1, 99);
    do_pass("t6_reload", 1'b0);
    chk("t6_first_load", ctrl2, 65535);

    // Random frames and ticks.
    for (int it = 0; it < 25; it++) begin
      int v [5];
      for (int n = 0; n < 5; n++) begin
        case ($urandom_range(0, 3))
          0: v[n] = 0;
          1: v[n] = 65535;
          default: v[n] = int'($urandom_range(0, 65535));
        endcase
      end
      if ($urandom_range(0, 4) != 0) do_frame(v[0], v[1], v[2], v[3], v[4]);
      repeat ($urandom_range(1, 3)) do_pass("rnd", 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
